// File: rtl/tug_of_war_ctrl.sv
// Match controller for the 9-light tug-of-war: key edges, point detection, scoring, restart.
// Latency: press/point pulses are combinational (0 cycles); field_reset/score/winner/game_over are registered (1 cycle).
// Backpressure: none; keys are sampled every cycle and presses outside PLAY are dropped.
module tug_of_war_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_l,
  input  logic               key_r,
  input  logic [8:0]         led,
  output logic               press_l,
  output logic               press_r,
  output logic               field_reset,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               point_l,
  output logic               point_r,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CLEAR      = 2'd0,
    S_PLAY       = 2'd1,
    S_HOLD       = 2'd2,
    S_MATCH_OVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               prev_l_q, prev_l_d;
  logic               prev_r_q, prev_r_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               field_reset_q, field_reset_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         winner_q, winner_d;

  logic               rise_l, rise_r;
  logic               in_play;
  logic [SCORE_W-1:0] inc_l, inc_r;

  // Only the two end lights matter for scoring; the rest are ignored.
  logic unused_led;
  assign unused_led = ^led[7:1];

  // Key edge detection and press/point pulses, all zero-latency.
  always_comb begin
    rise_l  = key_l & ~prev_l_q;
    rise_r  = key_r & ~prev_r_q;
    in_play = (state_q == S_PLAY);
    press_l = rise_l & in_play;
    press_r = rise_r & in_play;
    point_l = in_play & led[8] & press_l & ~press_r;
    point_r = in_play & led[0] & press_r & ~press_l;
    // Saturating increment; MATCH_OVER is reached at WIN so this never wraps.
    inc_l   = (score_l_q >= WIN) ? WIN : score_l_q + SCORE_W'(1);
    inc_r   = (score_r_q >= WIN) ? WIN : score_r_q + SCORE_W'(1);
  end

  // Next-state and registered-output logic for the match sequencer.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    winner_d   = winner_q;
    prev_l_d   = key_l;
    prev_r_d   = key_r;

    case (state_q)
      S_CLEAR: begin
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (point_l) begin
          score_l_d = inc_l;
          if (inc_l == WIN) begin
            state_d  = S_MATCH_OVER;
            winner_d = 2'b10;
          end else begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end else if (point_r) begin
          score_r_d = inc_r;
          if (inc_r == WIN) begin
            state_d  = S_MATCH_OVER;
            winner_d = 2'b01;
          end else begin
            state_d    = S_HOLD;
            hold_cnt_d = HOLD_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = S_CLEAR;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_MATCH_OVER: begin
        // Restart needs both keys down with at least one fresh edge.
        if ((rise_l | rise_r) & key_l & key_r) begin
          state_d   = S_CLEAR;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = 2'b00;
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    field_reset_d = (state_d == S_CLEAR) || (state_d == S_MATCH_OVER);
    game_over_d   = (state_d == S_MATCH_OVER);
  end

  // State registers with synchronous active-low reset; keys read as held through reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_CLEAR;
      prev_l_q      <= 1'b1;
      prev_r_q      <= 1'b1;
      hold_cnt_q    <= '0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      field_reset_q <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      prev_l_q      <= prev_l_d;
      prev_r_q      <= prev_r_d;
      hold_cnt_q    <= hold_cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      field_reset_q <= field_reset_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign field_reset = field_reset_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Bench for tug_of_war_ctrl: per-cycle vector table with expected outputs queued as each vector is driven.
// Latency: outputs sampled 3 time units after each driving edge.
// Backpressure: none; a watchdog bounds total run time.
module tb_tug_of_war_ctrl;

    logic       clk;
    logic       reset;
    logic       key_l, key_r;
    logic [8:0] led;
    logic       press_l, press_r, field_reset, point_l, point_r, game_over;
    logic [2:0] score_l, score_r;
    logic [1:0] winner;

    tug_of_war_ctrl #(.WIN_SCORE(7), .SCORE_W(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r), .led(led),
        .press_l(press_l), .press_r(press_r), .field_reset(field_reset),
        .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r),
        .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {press_l, press_r, point_l, point_r, field_reset, game_over, winner, score_l, score_r}
    typedef struct {
        string       name;
        logic        rst;
        logic        kl;
        logic        kr;
        logic [8:0]  led;
        logic [13:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [13:0] sb[$];
    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    task automatic add(input string name, input logic rst, input logic kl, input logic kr,
                       input logic [8:0] l, input logic pl, input logic pr, input logic ptl,
                       input logic ptr, input logic fr, input logic go, input logic [1:0] win,
                       input int sl, input int sr);
        vec_t v;
        v.name = name; v.rst = rst; v.kl = kl; v.kr = kr; v.led = l;
        v.exp  = {pl, pr, ptl, ptr, fr, go, win, 3'(sl), 3'(sr)};
        vecs.push_back(v);
    endtask

    // One point by one side from PLAY: press cycle, 4 frozen HOLD cycles, one CLEAR cycle.
    task automatic add_point(input bit left, input int sl, input int sr);
        int nl, nr;
        nl = left ? sl + 1 : sl;
        nr = left ? sr : sr + 1;
        add(left ? "pt_l" : "pt_r", 1, left, !left, left ? 9'h100 : 9'h001,
            left, !left, left, !left, 0, 0, 2'b00, sl, sr);
        for (int h = 0; h < 4; h++)
            add("pt_hold", 1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 2'b00, nl, nr);
        add("pt_clear", 1, 0, 0, 9'h000, 0, 0, 0, 0, 1, 0, 2'b00, nl, nr);
    endtask

    initial begin
        #100000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: simulation did not finish in time");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        logic [13:0] act, exp;
        vec_t v;

        reset = 1'b0; key_l = 1'b1; key_r = 1'b0; led = '0;

        @(posedge clk);
        #1;
        checks++;
        if (field_reset !== 1'b1 || game_over !== 1'b0 || winner !== 2'b00 ||
            score_l !== 3'd0 || score_r !== 3'd0 || press_l !== 1'b0 || press_r !== 1'b0 ||
            point_l !== 1'b0 || point_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: fr=%b go=%b win=%b sl=%0d sr=%0d pl=%b pr=%b ptl=%b ptr=%b",
                     field_reset, game_over, winner, score_l, score_r, press_l, press_r,
                     point_l, point_r);
        end

        // Reset: reset edges with key_l held, then one CLEAR cycle.
        add("rst_hold",    0, 1, 0, 9'h000, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add("rst_clear",   1, 1, 0, 9'h000, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add("play_held",   1, 1, 0, 9'h000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add("play_rel",    1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        // Left point with a right rise during HOLD that must be ignored.
        add("l_point",     1, 1, 0, 9'h100, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
        add("hold_rise_r", 1, 0, 1, 9'h001, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add("hold2",       1, 0, 0, 9'h001, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add("hold_rise_l", 1, 1, 0, 9'h100, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add("hold4",       1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        add("clear",       1, 0, 0, 9'h000, 0, 0, 0, 0, 1, 0, 2'b00, 1, 0);
        add("resume",      1, 0, 0, 9'h001, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        // Simultaneous presses never score.
        add("both_press",  1, 1, 1, 9'h001, 1, 1, 0, 0, 0, 0, 2'b00, 1, 0);
        add("both_rel",    1, 0, 0, 9'h001, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0);
        // Right player runs to WIN_SCORE.
        for (int i = 0; i < 6; i++) add_point(1'b0, 1, i);
        add("r_win",       1, 0, 1, 9'h001, 0, 1, 0, 1, 0, 0, 2'b00, 1, 6);
        add("mo_idle",     1, 0, 0, 9'h000, 0, 0, 0, 0, 1, 1, 2'b01, 1, 7);
        add("mo_rise_l",   1, 1, 0, 9'h100, 0, 0, 0, 0, 1, 1, 2'b01, 1, 7);
        add("mo_held_l",   1, 1, 0, 9'h000, 0, 0, 0, 0, 1, 1, 2'b01, 1, 7);
        add("mo_restart",  1, 1, 1, 9'h000, 0, 0, 0, 0, 1, 1, 2'b01, 1, 7);
        add("new_clear",   1, 0, 0, 9'h000, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add("new_play",    1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        // Reset in the middle of a HOLD after the third left point.
        add_point(1'b1, 0, 0);
        add_point(1'b1, 1, 0);
        add("l3",          1, 1, 0, 9'h100, 1, 0, 1, 0, 0, 0, 2'b00, 2, 0);
        add("rst_in_hold", 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 2'b00, 3, 0);
        add("post_rst",    1, 0, 0, 9'h000, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0);
        add("post_play",   1, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            reset = v.rst; key_l = v.kl; key_r = v.kr; led = v.led;
            sb.push_back(v.exp);
            #3;
            act = {press_l, press_r, point_l, point_r, field_reset, game_over, winner, score_l, score_r};
            exp = sb.pop_front();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s[%0d]: got %b expected %b (pl pr ptl ptr fr go win sl sr)",
                         v.name, i, act, exp);
            end
        end

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_of_war_ctrl.md
Name: tug_of_war_ctrl

Overview:
- Match controller for the 9-light tug-of-war playfield.
- Turns raw player key levels into single-cycle press pulses for the playfield.
- Detects when a player pushes the light off an end of the playfield, keeps per-player scores, and sequences each point: hold, playfield clear, resume.
- Declares a match winner at WIN_SCORE and waits for a two-key restart.

Parameters:
- WIN_SCORE, 7: score that ends the match; legal range 1..(2^SCORE_W - 1).
- SCORE_W, 3: width of each score counter.
- HOLD_CYCLES, 4: number of cycles the field is frozen after a point, before the clear; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising clk edge.
- key_l  in  1  left player key level; already synchronized; 1 = pressed.
- key_r  in  1  right player key level; already synchronized; 1 = pressed.
- led  in  9  playfield light status; led[8] is the leftmost light, led[0] the rightmost.
- press_l  out  1  one-cycle left-press pulse; drives playfield L.
- press_r  out  1  one-cycle right-press pulse; drives playfield R.
- field_reset  out  1  active-high playfield reset; registered.
- score_l  out  SCORE_W  left player score; registered.
- score_r  out  SCORE_W  right player score; registered.
- point_l  out  1  one-cycle pulse in the cycle the left player scores.
- point_r  out  1  one-cycle pulse in the cycle the right player scores.
- game_over  out  1  high while in MATCH_OVER; registered.
- winner  out  2  00 = none, 10 = left, 01 = right; registered.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=CLEAR; field_reset=1; scores=0; game_over=0; winner=00; hold count=0.
  - prev_l and prev_r are set to 1, so a key held through reset produces no press.
- Edge detection:
  - rise_l = key_l & ~prev_l; rise_r = key_r & ~prev_r.
  - prev_l and prev_r are updated every cycle in every state.
- Press outputs:
  - press_l = rise_l & (state==PLAY); press_r = rise_r & (state==PLAY).
  - Combinational, zero latency. Both are 0 in every other state.
- State CLEAR:
  - field_reset=1 for exactly one cycle, then go to PLAY with field_reset=0.
- State PLAY:
  - Left point: led[8] & press_l & ~press_r.
  - Right point: led[0] & press_r & ~press_l.
  - Simultaneous presses never score; the playfield resolves them.
  - On a point, in the same cycle: pulse point_l or point_r, and the scorer's count +1 on the next edge.
  - If the new score == WIN_SCORE: go to MATCH_OVER and set winner.
  - Otherwise: go to HOLD and load the hold count with HOLD_CYCLES-1.
- State HOLD:
  - Presses suppressed; field_reset=0.
  - Count down by 1 each cycle; at count 0, go to CLEAR.
  - A point therefore produces exactly HOLD_CYCLES HOLD cycles, then 1 CLEAR cycle, then PLAY.
- State MATCH_OVER:
  - game_over=1 and winner held; scores held; field_reset=1 continuously.
  - Exit when rise_l & rise_r occur in the same cycle, or when one key is held and the other rises.
  - Formally the exit condition is (rise_l|rise_r) & key_l & key_r.
  - On exit: scores=0, winner=00, game_over=0, go to CLEAR.
- Score arithmetic: saturates at WIN_SCORE; it can never wrap because MATCH_OVER is entered at WIN_SCORE.
- Mid-operation reset: the reset value applies from any state on the next edge; an in-progress hold is discarded.
- Keys held continuously generate no repeat pulses; a release followed by a press is required.

Test Plan:
- Reset held 2 cycles with key_l=1 throughout, then released -> field_reset=1 for the reset cycles plus 1 CLEAR cycle; no press_l pulse while key_l stays 1; scores=0, winner=00.
- In PLAY, led=9'b100000000 and key_l rises (key_r=0) -> press_l=1 for 1 cycle; point_l=1 in the same cycle; score_l 0->1; then 4 HOLD cycles with press suppressed; 1 CLEAR cycle with field_reset=1; PLAY resumes.
- led=9'b000000001, key_l and key_r rise in the same cycle -> press_l=press_r=1; point_l=point_r=0; scores unchanged.
- key_r rising during HOLD -> press_r stays 0 and scores are unchanged.
- Right player scores 7 times -> at the 7th point: score_r=7, game_over=1, winner=01, field_reset stays 1; a key_l rise alone causes no change; key_l held, then key_r rises -> scores=0, winner=00, CLEAR, then PLAY.
- reset=0 asserted during HOLD with score_l=3 -> next edge: score_l=0, state CLEAR, field_reset=1; no point pulses.
